uart_tx_sequencer: RTL and testbench

Sequences a 4-byte message through the UART transmitter of the UART-LED datapath. It latches the message and baud setting, then issues one write handshake per byte against TX_BUSY. It checks each byte looped back through the receiver and keeps error status. It sits between the user/control logic and the `uart_transmitter`/`uart_receiver` pair, replacing hand-driven Tx_WR sequencing.

---
 rtl/uart_tx_sequencer_pkg.sv | 38 +++
 rtl/uart_tx_sequencer_if.sv | 26 ++
 rtl/uart_tx_sequencer_timer.sv | 27 ++
 rtl/uart_tx_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_sequencer_pkg.sv
// Shared types and constants for the UART transmit sequencer: FSM states,
// error-flag bit positions, default baud select and per-baud divisors.
package uart_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    WAIT_TX = 3'd2,
    WAIT_RX = 3'd3,
    GAP     = 3'd4,
    DRAIN   = 3'd5,
    DONE    = 3'd6
  } state_t;

  // Bit positions inside err_flags = {timeout, mismatch, ferror, perror}.
  localparam int ERR_PERROR   = 0;
  localparam int ERR_FERROR   = 1;
  localparam int ERR_MISMATCH = 2;
  localparam int ERR_TIMEOUT  = 3;

  localparam logic [2:0] BAUD_DEFAULT = 3'b111;

  // Clock divisor per baud select, used to size frame-length waits.
  localparam int unsigned BAUD_DIV [8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};

  // Byte 0 is the most significant byte of the message.
  function automatic logic [7:0] msg_byte(input logic [31:0] m, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = m[31:24];
      2'd1:    b = m[23:16];
      2'd2:    b = m[15:8];
      default: b = m[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// UART-side bundle between the sequencer (master) and the transmitter/receiver pair (slave).
interface uart_tx_sequencer_if;
  logic [2:0] baud_select;
  logic       tx_en;
  logic       rx_en;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_perror;
  logic       rx_ferror;

  // Write handshake: tx_wr acts as valid and stays high with tx_data stable until
  // tx_busy (the acceptance indication) is sampled high; the byte is then in flight
  // until tx_busy returns low. rx_valid/rx_perror/rx_ferror are single-cycle strobes.
  modport master (
    output baud_select, tx_en, rx_en, tx_wr, tx_data,
    input  tx_busy, rx_data, rx_valid, rx_perror, rx_ferror
  );

  modport slave (
    input  baud_select, tx_en, rx_en, tx_wr, tx_data,
    output tx_busy, rx_data, rx_valid, rx_perror, rx_ferror
  );
endinterface

// File: rtl/uart_tx_sequencer_timer.sv
// Loadable down-counter shared by the phase watchdog and the inter-byte gap.
// expire is high while the count sits at zero.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/uart_tx_sequencer.sv
// Sends a latched 4-byte message through the UART transmitter one handshake per byte,
// checks each looped-back byte and keeps sticky error status.
module uart_tx_sequencer
  import uart_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int GAP_CYCLES     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] msg,
  input  logic [2:0]  baud_cfg,
  uart_tx_sequencer_if.master uif,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [1:0]  byte_idx,
  output logic [7:0]  err_count,
  output logic [3:0]  err_flags,
  output state_t      dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Loaded with N-1 so the phase is left after exactly N sampled cycles.
  localparam logic [TW-1:0] WD_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  state_t         state, nxt;
  logic           tmr_load, tmr_expire;
  logic [TW-1:0]  tmr_val;
  logic [3:0]     flag_set;
  logic           err_inc, accept, advance, drain_end;
  logic           tx_wr_d, busy_d, done_d;
  logic           tx_wr_q;
  logic [7:0]     tx_data_q;
  logic [2:0]     baud_q;
  logic [31:0]    msg_q;

  seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    tmr_load  = 1'b0;
    tmr_val   = WD_LOAD;
    flag_set  = '0;
    err_inc   = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    drain_end = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          nxt      = WRITE;
          tmr_load = 1'b1;
          accept   = 1'b1;
        end
      end
      WRITE: begin
        if (abort) begin
          nxt      = DRAIN;
          tmr_load = 1'b1;
        end else if (uif.tx_busy) begin
          nxt      = WAIT_TX;
          tmr_load = 1'b1;
        end else if (tmr_expire) begin
          nxt                   = GAP;
          tmr_load              = 1'b1;
          tmr_val               = GAP_LOAD;
          flag_set[ERR_TIMEOUT] = 1'b1;
          err_inc               = 1'b1;
        end
      end
      WAIT_TX: begin
        if (abort) begin
          nxt      = DRAIN;
          tmr_load = 1'b1;
        end else if (!uif.tx_busy) begin
          nxt      = WAIT_RX;
          tmr_load = 1'b1;
        end else if (tmr_expire) begin
          nxt                   = GAP;
          tmr_load              = 1'b1;
          tmr_val               = GAP_LOAD;
          flag_set[ERR_TIMEOUT] = 1'b1;
          err_inc               = 1'b1;
        end
      end
      WAIT_RX: begin
        if (abort) begin
          nxt      = DRAIN;
          tmr_load = 1'b1;
        end else if (uif.rx_valid || uif.rx_perror || uif.rx_ferror) begin
          // Several flags may hit on the same strobe; the byte still counts once.
          nxt                    = GAP;
          tmr_load               = 1'b1;
          tmr_val                = GAP_LOAD;
          flag_set[ERR_PERROR]   = uif.rx_perror;
          flag_set[ERR_FERROR]   = uif.rx_ferror;
          flag_set[ERR_MISMATCH] = uif.rx_valid && (uif.rx_data != tx_data_q);
          err_inc                = |flag_set;
        end else if (tmr_expire) begin
          nxt                   = GAP;
          tmr_load              = 1'b1;
          tmr_val               = GAP_LOAD;
          flag_set[ERR_TIMEOUT] = 1'b1;
          err_inc               = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          nxt      = DRAIN;
          tmr_load = 1'b1;
        end else if (tmr_expire) begin
          if (byte_idx == 2'd3) begin
            nxt = DONE;
          end else begin
            nxt      = WRITE;
            tmr_load = 1'b1;
            advance  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!uif.tx_busy || tmr_expire) begin
          nxt                   = DONE;
          drain_end             = 1'b1;
          flag_set[ERR_TIMEOUT] = uif.tx_busy;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    tx_wr_d = (nxt == WRITE);
    busy_d  = nxt inside {WRITE, WAIT_TX, WAIT_RX, GAP, DRAIN};
    done_d  = (nxt == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
      baud_q    <= BAUD_DEFAULT;
      msg_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      byte_idx  <= '0;
      err_count <= '0;
      err_flags <= '0;
    end else begin
      tx_wr_q <= tx_wr_d;
      busy    <= busy_d;
      done    <= done_d;
      if (accept) begin
        msg_q     <= msg;
        baud_q    <= baud_cfg;
        tx_data_q <= msg[31:24];
        byte_idx  <= '0;
        aborted   <= 1'b0;
        err_flags <= '0;
      end else begin
        err_flags <= err_flags | flag_set;
      end
      if (advance) begin
        byte_idx  <= byte_idx + 2'd1;
        tx_data_q <= msg_byte(msg_q, byte_idx + 2'd1);
      end
      if (drain_end) aborted <= 1'b1;
      if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  assign uif.tx_wr       = tx_wr_q;
  assign uif.tx_data     = tx_data_q;
  assign uif.baud_select = baud_q;
  assign uif.tx_en       = reset;
  assign uif.rx_en       = reset;
  assign dbg_state       = state;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a cycle-level UART loopback model.
module tb_uart_tx_sequencer;
  import uart_seq_pkg::*;

  localparam int TO  = 100;
  localparam int GP  = 16;
  localparam int BL  = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] msg = '0;
  logic [2:0]  baud_cfg = '0;
  logic        busy, done, aborted;
  logic [1:0]  byte_idx;
  logic [7:0]  err_count;
  logic [3:0]  err_flags;
  state_t      dbg_state;

  uart_tx_sequencer_if uif();

  uart_tx_sequencer #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .msg       (msg),
    .baud_cfg  (baud_cfg),
    .uif       (uif.master),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .byte_idx  (byte_idx),
    .err_count (err_count),
    .err_flags (err_flags),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- UART loopback model ----------------
  logic stuck_tx = 1'b0;
  logic hold_busy = 1'b0;
  logic perr_all = 1'b0;
  int   perr_idx = -1;
  int   corrupt_idx = -1;
  int   m_phase = 0;
  int   m_cnt = 0;
  int   m_idx = 0;
  logic [7:0] m_byte = '0;

  initial begin
    uif.tx_busy = 1'b0; uif.rx_data = '0; uif.rx_valid = 1'b0;
    uif.rx_perror = 1'b0; uif.rx_ferror = 1'b0;
    forever begin
      @(posedge clk); #1;
      uif.rx_valid = 1'b0; uif.rx_perror = 1'b0; uif.rx_ferror = 1'b0;
      if (!reset) begin
        m_phase = 0;
        uif.tx_busy = 1'b0;
      end else begin
        case (m_phase)
          0: if (uif.tx_wr && !stuck_tx) begin
               m_byte = uif.tx_data; m_idx = int'(byte_idx); m_phase = 1;
             end
          1: begin uif.tx_busy = 1'b1; m_cnt = BL; m_phase = 2; end
          2: if (!hold_busy) begin
               m_cnt--;
               if (m_cnt == 0) begin uif.tx_busy = 1'b0; m_cnt = 3; m_phase = 3; end
             end
          3: begin
               m_cnt--;
               if (m_cnt == 0) begin
                 if (perr_all || m_idx == perr_idx) uif.rx_perror = 1'b1;
                 else begin
                   uif.rx_valid = 1'b1;
                   uif.rx_data  = (m_idx == corrupt_idx) ? 8'h89 : m_byte;
                 end
                 m_phase = 0;
               end
             end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // ---------------- output monitor ----------------
  int wr_count = 0;
  int done_count = 0;
  int wr_run = 0;
  logic tx_wr_prev = 1'b0;
  logic busy_at_done = 1'b0;
  logic [7:0] got_arr [1024];
  int len_arr [1024];

  initial begin
    forever begin
      @(negedge clk);
      if (uif.tx_wr && !tx_wr_prev) begin
        got_arr[wr_count % 1024] = uif.tx_data;
        wr_count++;
        wr_run = 0;
      end
      if (uif.tx_wr) wr_run++;
      else if (tx_wr_prev) len_arr[(wr_count - 1) % 1024] = wr_run;
      tx_wr_prev = uif.tx_wr;
      if (done) begin
        done_count++;
        busy_at_done = uif.tx_busy;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    stuck_tx = 1'b0; hold_busy = 1'b0; perr_all = 1'b0;
    perr_idx = -1; corrupt_idx = -1;
    exp_q.delete();
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(1);
  endtask

  task automatic start_msg(input logic [31:0] m, input logic [2:0] b);
    @(negedge clk);
    msg = m; baud_cfg = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_tx_wr", uif.tx_wr, 1'b1);
    check_eq("start_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back(m[31-8*i -: 8]);
  endtask

  task automatic wait_done(input string tag, input int base, input int limit);
    int n = 0;
    while (done_count == base && n < limit) begin
      @(negedge clk);
      n++;
    end
    wait_cycles(2);
    check_eq({tag, "_done_pulses"}, done_count - base, 1);
  endtask

  task automatic check_bytes(input string tag, input int base, input int n);
    logic [7:0] e;
    check_eq({tag, "_wr_count"}, wr_count - base, n);
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check_eq($sformatf("%s_byte%0d", tag, i), got_arr[(base + i) % 1024], e);
    end
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int wbase, dbase, n;

    // Reset values while reset is held low.
    wait_cycles(3);
    check_eq("rst_tx_wr", uif.tx_wr, 1'b0);
    check_eq("rst_tx_data", uif.tx_data, 8'h00);
    check_eq("rst_status", {busy, done, aborted, byte_idx, err_flags}, 0);
    check_eq("rst_err_count", err_count, 8'h00);
    check_eq("rst_en", {uif.tx_en, uif.rx_en}, 2'b00);
    check_eq("rst_baud", uif.baud_select, 3'b111);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("en_after_rst", {uif.tx_en, uif.rx_en}, 2'b11);

    // Clean loopback.
    wbase = wr_count; dbase = done_count;
    start_msg(32'hA888C123, 3'b111);
    wait_done("loop", dbase, 2000);
    check_eq("loop_wr_len", len_arr[wbase % 1024], 2);
    check_bytes("loop", wbase, 4);
    check_eq("loop_err_count", err_count, 8'd0);
    check_eq("loop_err_flags", err_flags, 4'b0000);
    check_eq("loop_baud", uif.baud_select, 3'b111);
    check_eq("loop_busy_idle", {busy, aborted}, 2'b00);

    // Byte 1 corrupted on the loopback; a re-start mid-message must be ignored.
    do_reset();
    corrupt_idx = 1;
    wbase = wr_count; dbase = done_count;
    start_msg(32'hA888C123, 3'b011);
    n = 0;
    while (byte_idx != 2'd1 && n < 500) begin @(negedge clk); n++; end
    msg = 32'hFFFFFFFF; baud_cfg = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("corrupt", dbase, 2000);
    check_bytes("corrupt", wbase, 4);
    check_eq("corrupt_err_count", err_count, 8'd1);
    check_eq("corrupt_err_flags", err_flags, 4'b0100);
    check_eq("restart_ignored_baud", uif.baud_select, 3'b011);

    // Parity error on the last byte.
    do_reset();
    perr_idx = 3;
    wbase = wr_count; dbase = done_count;
    start_msg(32'h5A3C0FF0, 3'b100);
    wait_done("perr", dbase, 2000);
    check_bytes("perr", wbase, 4);
    check_eq("perr_err_count", err_count, 8'd1);
    check_eq("perr_err_flags", err_flags, 4'b0001);
    check_eq("perr_baud", uif.baud_select, 3'b100);

    // Transmitter never goes busy: every byte times out in WRITE.
    do_reset();
    stuck_tx = 1'b1;
    wbase = wr_count; dbase = done_count;
    start_msg(32'hA888C123, 3'b111);
    wait_done("stuck", dbase, 2000);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("stuck_wr_len%0d", i), len_arr[(wbase + i) % 1024], TO);
    check_bytes("stuck", wbase, 4);
    check_eq("stuck_err_count", err_count, 8'd4);
    check_eq("stuck_err_flags", err_flags, 4'b1000);
    stuck_tx = 1'b0;

    // Abort handling.
    do_reset();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check_eq("abort_idle_state", 32'(dbg_state), 32'(IDLE));
    check_eq("abort_idle_aborted", aborted, 1'b0);
    @(negedge clk); msg = 32'h12345678; start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check_eq("start_abort_busy", {busy, uif.tx_wr}, 2'b00);
    check_eq("start_abort_state", 32'(dbg_state), 32'(IDLE));
    wbase = wr_count; dbase = done_count;
    start_msg(32'hA888C123, 3'b111);
    n = 0;
    while (byte_idx != 2'd2 && n < 500) begin @(negedge clk); n++; end
    hold_busy = 1'b1;
    n = 0;
    while (dbg_state != WAIT_TX && n < 50) begin @(negedge clk); n++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_cycles(10);
    check_eq("drain_state", 32'(dbg_state), 32'(DRAIN));
    check_eq("drain_no_done", done_count - dbase, 0);
    check_eq("drain_busy_wr", {busy, uif.tx_wr}, 2'b10);
    hold_busy = 1'b0;
    wait_done("abort", dbase, 200);
    check_bytes("abort", wbase, 3);
    check_eq("abort_aborted", aborted, 1'b1);
    check_eq("abort_byte_idx", byte_idx, 2'd2);
    check_eq("abort_tx_busy_at_done", busy_at_done, 1'b0);
    check_eq("abort_busy", busy, 1'b0);

    // Saturation: every byte reports a parity error.
    do_reset();
    perr_all = 1'b1;
    for (int k = 0; k < 65; k++) begin
      dbase = done_count;
      start_msg(32'h01020304, 3'b101);
      wait_done("sat", dbase, 2000);
      exp_q.delete();
      if (k == 62) check_eq("sat_err_count_252", err_count, 8'd252);
      if (k == 63) check_eq("sat_err_count_255", err_count, 8'd255);
    end
    check_eq("sat_err_count_hold", err_count, 8'd255);
    check_eq("sat_err_flags", err_flags, 4'b0001);
    perr_all = 1'b0;

    // Asynchronous reset while tx_wr is high.
    start_msg(32'hDEADBEEF, 3'b001);
    exp_q.delete();
    #3;
    reset = 1'b0;
    #1;
    check_eq("async_tx_wr", uif.tx_wr, 1'b0);
    check_eq("async_tx_data", uif.tx_data, 8'h00);
    check_eq("async_err_count", err_count, 8'd0);
    check_eq("async_status", {busy, done, aborted, byte_idx, err_flags}, 0);
    check_eq("async_baud", uif.baud_select, 3'b111);
    check_eq("async_en", {uif.tx_en, uif.rx_en}, 2'b00);
    check_eq("async_state", 32'(dbg_state), 32'(IDLE));
    wait_cycles(3);

    // Start accepted on the first edge after deassertion.
    @(negedge clk);
    reset = 1'b1;
    wbase = wr_count; dbase = done_count;
    msg = 32'h11223344; baud_cfg = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("recover_tx_wr", uif.tx_wr, 1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back(msg[31-8*i -: 8]);
    wait_done("recover", dbase, 2000);
    check_bytes("recover", wbase, 4);
    check_eq("recover_baud", uif.baud_select, 3'b010);
    check_eq("recover_err_count", err_count, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
